// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the UART-TX MMIO block and the arbiter in front of its command port.
// Register map, lock FSM encoding and the command bundle routed through the grant mux.
package uart_tx_mmio_pkg;

    localparam logic [31:0] UART_TX_TAIL_ADDR = 32'h100;
    localparam logic [31:0] UART_TX_HEAD_ADDR = 32'h104;
    localparam int unsigned UART_TX_BUF_WORDS = 64;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } lock_state_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a lock override; purely combinational.
// With no request pending the grant rests on the round-robin pointer.
module rr_arbiter2
    import uart_tx_mmio_pkg::*;
(
    input  logic [1:0]  req,
    input  logic        ptr,
    input  lock_state_e lock_state,
    output logic        grant
);

    always_comb begin
        // NOTE: default assignment first so every path drives grant and no latch is inferred.
        grant = ptr;
        case (lock_state)
            LOCKED0: grant = 1'b0;
            LOCKED1: grant = 1'b1;
            default: begin
                if (req == 2'b01) begin
                    grant = 1'b0;
                end else if (req == 2'b10) begin
                    grant = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/mmio_uart_tx_arbiter.sv
// Shares the UART-TX MMIO command port between the core data port (req0) and the debug print engine (req1).
// Round-robin arbitration, bus lock for atomic pushes with a forced-release timeout, read-response routing.
module mmio_uart_tx_arbiter
    import uart_tx_mmio_pkg::*;
#(
    parameter int unsigned LOCK_MAX_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_cmd_start,
    input  logic        req0_cmd_write,
    input  logic        req0_lock,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_cmd_ready,
    output logic [31:0] req0_rdata,
    output logic        req0_rdata_valid,
    input  logic        req1_cmd_start,
    input  logic        req1_cmd_write,
    input  logic        req1_lock,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_cmd_ready,
    output logic [31:0] req1_rdata,
    output logic        req1_rdata_valid,
    output logic        dev_cmd_start,
    output logic        dev_cmd_write,
    output logic [31:0] dev_addr,
    output logic [31:0] dev_wdata,
    input  logic        dev_cmd_ready,
    input  logic [31:0] dev_rdata,
    output logic        lock_timeout
);

    localparam int CNT_W = $clog2(LOCK_MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX_CYCLES - 1);

    lock_state_e      lock_state;
    logic             rr_ptr;
    logic [CNT_W-1:0] lock_cnt;
    logic             resp_pending;
    logic             resp_owner;

    logic grant_raw;
    logic grant;
    cmd_t cmd0;
    cmd_t cmd1;
    cmd_t cmd_sel;
    logic start_sel;
    logic lock_sel;
    logic accept;
    logic locked;
    logic lock_owner;
    logic owner_lock;
    logic timeout_hit;

    rr_arbiter2 u_rr (
        .req        ({req1_cmd_start, req0_cmd_start}),
        .ptr        (rr_ptr),
        .lock_state (lock_state),
        .grant      (grant_raw)
    );

    // Reset parks the mux on req0 with nothing issued, regardless of the stale pointer.
    assign grant = reset ? 1'b0 : grant_raw;

    assign cmd0 = '{write: req0_cmd_write, addr: req0_addr, wdata: req0_wdata};
    assign cmd1 = '{write: req1_cmd_write, addr: req1_addr, wdata: req1_wdata};

    assign cmd_sel   = grant ? cmd1 : cmd0;
    assign start_sel = grant ? req1_cmd_start : req0_cmd_start;
    assign lock_sel  = grant ? req1_lock : req0_lock;

    assign dev_cmd_start = start_sel & ~reset;
    assign dev_cmd_write = cmd_sel.write;
    assign dev_addr      = cmd_sel.addr;
    assign dev_wdata     = cmd_sel.wdata;

    assign req0_cmd_ready = ~grant & dev_cmd_ready & ~reset;
    assign req1_cmd_ready =  grant & dev_cmd_ready & ~reset;
    assign accept         = dev_cmd_start & dev_cmd_ready;

    assign locked     = (lock_state == LOCKED0) || (lock_state == LOCKED1);
    assign lock_owner = (lock_state == LOCKED1);
    assign owner_lock = lock_owner ? req1_lock : req0_lock;
    // A holder that drops lock in the last cycle releases normally, not by timeout.
    assign timeout_hit  = locked & owner_lock & (lock_cnt == CNT_LAST);
    assign lock_timeout = timeout_hit & ~reset;

    // Device read data is already registered, so routing it adds no latency.
    assign req0_rdata_valid = resp_pending & ~resp_owner & ~reset;
    assign req1_rdata_valid = resp_pending &  resp_owner & ~reset;
    assign req0_rdata       = req0_rdata_valid ? dev_rdata : '0;
    assign req1_rdata       = req1_rdata_valid ? dev_rdata : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_state   <= UNLOCKED;
            rr_ptr       <= 1'b0;
            lock_cnt     <= '0;
            resp_pending <= 1'b0;
            resp_owner   <= 1'b0;
        end else begin
            resp_pending <= accept & ~cmd_sel.write;
            if (accept && !cmd_sel.write) begin
                resp_owner <= grant;
            end

            case (lock_state)
                UNLOCKED: begin
                    if (accept) begin
                        if (lock_sel) begin
                            lock_state <= grant ? LOCKED1 : LOCKED0;
                            lock_cnt   <= '0;
                        end else begin
                            rr_ptr <= ~grant;
                        end
                    end
                end
                LOCKED0, LOCKED1: begin
                    if (!owner_lock || timeout_hit) begin
                        lock_state <= UNLOCKED;
                        rr_ptr     <= ~lock_owner;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: lock_state <= UNLOCKED;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a rule-level model.
// A small UART-TX MMIO device model answers the arbiter's command port.
module tb_mmio_uart_tx_arbiter;
    import uart_tx_mmio_pkg::*;

    localparam int MAXC = 4;
    localparam int MEM_WORDS = UART_TX_BUF_WORDS + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        st [0:1];
    logic        wr [0:1];
    logic        lk [0:1];
    logic [31:0] ad [0:1];
    logic [31:0] wd [0:1];

    logic        req0_cmd_ready, req1_cmd_ready;
    logic [31:0] req0_rdata, req1_rdata;
    logic        req0_rdata_valid, req1_rdata_valid;
    logic        dev_cmd_start, dev_cmd_write;
    logic [31:0] dev_addr, dev_wdata;
    logic        dev_cmd_ready;
    logic [31:0] dev_rdata;
    logic        lock_timeout;

    always #5 clk = ~clk;

    mmio_uart_tx_arbiter #(.LOCK_MAX_CYCLES(MAXC)) dut (
        .clk              (clk),
        .reset            (reset),
        .req0_cmd_start   (st[0]),
        .req0_cmd_write   (wr[0]),
        .req0_lock        (lk[0]),
        .req0_addr        (ad[0]),
        .req0_wdata       (wd[0]),
        .req0_cmd_ready   (req0_cmd_ready),
        .req0_rdata       (req0_rdata),
        .req0_rdata_valid (req0_rdata_valid),
        .req1_cmd_start   (st[1]),
        .req1_cmd_write   (wr[1]),
        .req1_lock        (lk[1]),
        .req1_addr        (ad[1]),
        .req1_wdata       (wd[1]),
        .req1_cmd_ready   (req1_cmd_ready),
        .req1_rdata       (req1_rdata),
        .req1_rdata_valid (req1_rdata_valid),
        .dev_cmd_start    (dev_cmd_start),
        .dev_cmd_write    (dev_cmd_write),
        .dev_addr         (dev_addr),
        .dev_wdata        (dev_wdata),
        .dev_cmd_ready    (dev_cmd_ready),
        .dev_rdata        (dev_rdata),
        .lock_timeout     (lock_timeout)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Device: buffer words, then tail, then head.
    logic [31:0] dev_mem [0:MEM_WORDS-1];

    function automatic int dev_index(input logic [31:0] a);
        if (a < UART_TX_BUF_WORDS * 4) return int'(a[31:2]);
        if (a == UART_TX_TAIL_ADDR) return UART_TX_BUF_WORDS;
        if (a == UART_TX_HEAD_ADDR) return UART_TX_BUF_WORDS + 1;
        return -1;
    endfunction

    function automatic logic [31:0] dev_read(input logic [31:0] a);
        int idx = dev_index(a);
        return (idx < 0) ? 32'h0 : dev_mem[idx];
    endfunction

    // Reference model state: lock holder (-1 = none), cycles held, favoured requester, pending response.
    int          m_owner = -1;
    int          m_held = 0;
    int          m_fav = 0;
    bit          m_pend = 1'b0;
    int          m_pend_owner = 0;
    logic [31:0] m_pend_data = 32'h0;

    logic obs_ready0, obs_ready1, obs_v0, obs_v1, obs_to;
    logic [31:0] obs_rdata0;

    task automatic cycle();
        int          g;
        bit          locked, exp_start, acc, exp_v0, exp_v1, exp_to;
        logic [31:0] rd;
        bit          d_acc, d_wr;
        logic [31:0] d_addr, d_wdata;
        #3;
        locked = !reset && (m_owner >= 0);
        if (reset) g = 0;
        else if (locked) g = m_owner;
        else if (st[0] && st[1]) g = m_fav;
        else if (st[1]) g = 1;
        else g = 0;
        exp_start = !reset && st[g];
        acc       = exp_start && dev_cmd_ready;
        exp_v0    = !reset && m_pend && (m_pend_owner == 0);
        exp_v1    = !reset && m_pend && (m_pend_owner == 1);
        exp_to    = locked && lk[m_owner] && (m_held == MAXC - 1);

        obs_ready0 = req0_cmd_ready;
        obs_ready1 = req1_cmd_ready;
        obs_v0     = req0_rdata_valid;
        obs_v1     = req1_rdata_valid;
        obs_rdata0 = req0_rdata;
        obs_to     = lock_timeout;

        check("dev_cmd_start", 32'(dev_cmd_start), 32'(exp_start));
        if (exp_start) begin
            check("dev_cmd_write", 32'(dev_cmd_write), 32'(wr[g]));
            check("dev_addr", dev_addr, ad[g]);
            check("dev_wdata", dev_wdata, wd[g]);
        end
        if (reset) check("reset_dev_addr", dev_addr, ad[0]);
        if (!reset && (locked || st[0]))
            check("req0_cmd_ready", 32'(req0_cmd_ready), 32'(g == 0 && dev_cmd_ready));
        if (!reset && (locked || st[1]))
            check("req1_cmd_ready", 32'(req1_cmd_ready), 32'(g == 1 && dev_cmd_ready));
        check("req0_rdata_valid", 32'(req0_rdata_valid), 32'(exp_v0));
        check("req1_rdata_valid", 32'(req1_rdata_valid), 32'(exp_v1));
        check("req0_rdata", req0_rdata, exp_v0 ? m_pend_data : 32'h0);
        check("req1_rdata", req1_rdata, exp_v1 ? m_pend_data : 32'h0);
        check("lock_timeout", 32'(lock_timeout), 32'(exp_to));

        rd = dev_read(ad[g]);
        if (reset) begin
            m_owner = -1;
            m_held  = 0;
            m_fav   = 0;
            m_pend  = 1'b0;
        end else begin
            m_pend = acc && !wr[g];
            if (m_pend) begin
                m_pend_owner = g;
                m_pend_data  = rd;
            end
            if (m_owner < 0) begin
                if (acc && lk[g]) begin
                    m_owner = g;
                    m_held  = 0;
                end else if (acc) begin
                    m_fav = 1 - g;
                end
            end else if (!lk[m_owner] || (m_held == MAXC - 1)) begin
                m_fav   = 1 - m_owner;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end

        d_acc   = dev_cmd_start && dev_cmd_ready;
        d_wr    = dev_cmd_write;
        d_addr  = dev_addr;
        d_wdata = dev_wdata;
        @(posedge clk);
        #1;
        if (d_acc) begin
            if (d_wr) begin
                if (dev_index(d_addr) >= 0) dev_mem[dev_index(d_addr)] = d_wdata;
            end else begin
                dev_rdata = dev_read(d_addr);
            end
        end
    endtask

    task automatic drive(input int r, input bit s, input bit w, input bit l,
                         input logic [31:0] a, input logic [31:0] d);
        st[r] = s;
        wr[r] = w;
        lk[r] = l;
        ad[r] = a;
        wd[r] = d;
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return UART_TX_TAIL_ADDR;
            1:       return UART_TX_HEAD_ADDR;
            2:       return 32'h200 + {$urandom_range(0, 15), 2'b00};
            default: return {$urandom_range(0, UART_TX_BUF_WORDS - 1), 2'b00};
        endcase
    endfunction

    initial begin
        int first_to;
        for (int i = 0; i < MEM_WORDS; i++) dev_mem[i] = $urandom();
        dev_rdata     = 32'h0;
        dev_cmd_ready = 1'b1;
        idle_all();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        idle_all();
        cycle();

        // Single read of head.
        dev_mem[UART_TX_BUF_WORDS + 1] = 32'h5;
        drive(0, 1'b1, 1'b0, 1'b0, UART_TX_HEAD_ADDR, 32'h0);
        cycle();
        check("single_read_ready", 32'(obs_ready0), 32'h1);
        idle_all();
        cycle();
        check("single_read_valid", 32'(obs_v0), 32'h1);
        check("single_read_data", obs_rdata0, 32'h5);
        check("single_read_other", 32'(obs_v1), 32'h0);

        // Contention: alternating grants starting with req0.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b1, 1'b0, 1'b0, {i[5:0], 2'b00}, 32'h0);
            drive(1, 1'b1, 1'b0, 1'b0, UART_TX_TAIL_ADDR, 32'h0);
            cycle();
            check("contention_grant0", 32'(obs_ready0), 32'(i % 2 == 0));
        end
        idle_all();
        cycle();

        // Atomic push by req0 while req1 keeps requesting.
        do_reset();
        dev_mem[UART_TX_BUF_WORDS] = 32'h7;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive(0, 1'b1, 1'b0, 1'b1, UART_TX_TAIL_ADDR, 32'h0);
                1: drive(0, 1'b1, 1'b1, 1'b1, 32'h08, 32'h41424344);
                2: drive(0, 1'b1, 1'b1, 1'b0, UART_TX_TAIL_ADDR, 32'h9);
                default: drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            endcase
            drive(1, 1'b1, 1'b0, 1'b0, UART_TX_HEAD_ADDR, 32'h0);
            cycle();
            check("push_req1_ready", 32'(obs_ready1), 32'(i == 3));
        end
        check("push_buf_word", dev_mem[2], 32'h41424344);
        check("push_tail", dev_mem[UART_TX_BUF_WORDS], 32'h9);
        idle_all();
        cycle();

        // Lock timeout: req1 locks once and then idles with lock held.
        do_reset();
        first_to = -1;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                drive(1, 1'b1, 1'b0, 1'b1, UART_TX_HEAD_ADDR, 32'h0);
                drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end else begin
                drive(1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
                drive(0, 1'b1, 1'b0, 1'b0, UART_TX_TAIL_ADDR, 32'h0);
            end
            cycle();
            if (obs_to && first_to < 0) first_to = i;
            if (i == 4) check("timeout_req0_blocked", 32'(obs_ready0), 32'h0);
            if (i == 5) check("timeout_req0_granted", 32'(obs_ready0), 32'h1);
        end
        check("timeout_cycle", 32'(first_to), 32'd4);
        idle_all();
        cycle();

        // Backpressure: stalled device, then the pointer holder wins.
        do_reset();
        drive(0, 1'b1, 1'b0, 1'b0, UART_TX_HEAD_ADDR, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, UART_TX_TAIL_ADDR, 32'h0);
        dev_cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_ready", {obs_ready0, obs_ready1, obs_v0, obs_v1}, 32'h0);
        end
        dev_cmd_ready = 1'b1;
        cycle();
        check("stall_release_grant", {obs_ready1, obs_ready0}, 32'h1);
        idle_all();
        cycle();

        // Reset right after an accepted read from req0.
        do_reset();
        drive(0, 1'b1, 1'b0, 1'b0, UART_TX_HEAD_ADDR, 32'h0);
        cycle();
        idle_all();
        reset = 1'b1;
        cycle();
        check("reset_drop_valid", 32'(obs_v0), 32'h0);
        reset = 1'b0;
        cycle();
        check("after_reset_valid", 32'(obs_v0), 32'h0);
        drive(0, 1'b1, 1'b0, 1'b0, UART_TX_HEAD_ADDR, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, UART_TX_TAIL_ADDR, 32'h0);
        cycle();
        check("after_reset_rr_ptr", {obs_ready1, obs_ready0}, 32'h1);
        idle_all();
        cycle();

        // Randomized traffic with sticky locks, stalls and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 299) == 0);
            dev_cmd_ready = ($urandom_range(0, 9) < 8);
            for (int r = 0; r < 2; r++) begin
                st[r] = ($urandom_range(0, 9) < 7);
                wr[r] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) lk[r] = ~lk[r];
                ad[r] = rand_addr();
                wd[r] = $urandom();
            end
            cycle();
        end
        reset         = 1'b0;
        dev_cmd_ready = 1'b1;
        idle_all();
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
